// File: rtl/uc_multiciclo.sv
// uc_multiciclo -- multi-cycle control sequencer for the RV64I DataFlow datapath.
// Steps each instruction through FETCH -> DECODE -> EXEC -> (MEM) -> (WB) and
// drives the PC, register-file, data-memory and ULA controls.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   opcode/funct3/funct7  instruction fields from the instruction register
//   zero                  ULA result == 0 (meaningful in EXEC)
//   mem_ready             data memory finishes the current access this cycle
//   ir_load               instruction register load (last FETCH cycle)
//   atualiza_pc, pc_src   PC write enable; 0: PC+4, 1: PC+imm
//   WeR, WeDM, ReDM       register-file write, data-memory write/read requests
//   soma_ou_subtrai       ULA op (00 add, 01 sub)
//   ula_src_b             ULA B operand (0 rs2, 1 immediate)
//   wb_sel                write-back source (00 ULA, 01 doutDM, 10 PC+4)
//   estado                current state (debug)
//   illegal               sticky flag: unsupported instruction decoded
module uc_multiciclo #(
  parameter int IMEM_LAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       ir_load,
  output logic       atualiza_pc,
  output logic       pc_src,
  output logic       WeR,
  output logic       WeDM,
  output logic       ReDM,
  output logic [1:0] soma_ou_subtrai,
  output logic       ula_src_b,
  output logic [1:0] wb_sel,
  output logic [2:0] estado,
  output logic       illegal
);

  localparam logic [2:0] FETCH  = 3'd0;
  localparam logic [2:0] DECODE = 3'd1;
  localparam logic [2:0] EXEC   = 3'd2;
  localparam logic [2:0] MEM    = 3'd3;
  localparam logic [2:0] WB     = 3'd4;
  localparam logic [2:0] TRAP   = 3'd5;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam int              CNT_W    = (IMEM_LAT > 1) ? $clog2(IMEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IMEM_LAT - 1);

  logic [2:0]       state_r, state_d;
  logic [CNT_W-1:0] cnt_r;
  logic [6:0]       op_r;
  logic [2:0]       f3_r;
  logic [6:0]       f7_r;
  logic             illegal_r;

  logic fetch_last, legal, alu_sub, use_imm, taken;

  // Branches only support beq/bne; every other supported opcode accepts any funct3.
  function automatic logic op_legal(input logic [6:0] op, input logic [2:0] f3);
    case (op)
      OP_R, OP_IALU, OP_LOAD, OP_STORE, OP_JAL: op_legal = 1'b1;
      OP_BRANCH: op_legal = (f3 == 3'b000) || (f3 == 3'b001);
      default:   op_legal = 1'b0;
    endcase
  endfunction

  assign fetch_last = (cnt_r == CNT_LAST);
  assign legal      = op_legal(opcode, funct3);
  assign alu_sub    = ((op_r == OP_R) && (f3_r == 3'b000) && (f7_r == 7'b0100000))
                    || (op_r == OP_BRANCH);
  assign use_imm    = (op_r == OP_IALU) || (op_r == OP_LOAD) || (op_r == OP_STORE);
  assign taken      = ((f3_r == 3'b000) && zero) || ((f3_r == 3'b001) && !zero);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= FETCH;
      cnt_r     <= '0;
      op_r      <= '0;
      f3_r      <= '0;
      f7_r      <= '0;
      illegal_r <= 1'b0;
    end else begin
      state_r <= state_d;
      // Counter only advances in FETCH and is re-armed for the next fetch.
      if (state_r == FETCH && !fetch_last) cnt_r <= cnt_r + CNT_W'(1);
      else                                 cnt_r <= '0;
      if (state_r == DECODE) begin
        op_r <= opcode;
        f3_r <= funct3;
        f7_r <= funct7;
        if (!legal) illegal_r <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_r;
    case (state_r)
      FETCH:  if (fetch_last) state_d = DECODE;
      DECODE: state_d = legal ? EXEC : TRAP;
      EXEC: begin
        case (op_r)
          OP_LOAD, OP_STORE: state_d = MEM;
          OP_BRANCH:         state_d = FETCH;
          default:           state_d = WB;
        endcase
      end
      MEM:    if (mem_ready) state_d = (op_r == OP_STORE) ? FETCH : WB;
      WB:     state_d = FETCH;
      TRAP:   state_d = TRAP;
      default: state_d = FETCH;
    endcase
  end

  // Outputs are forced low while reset is asserted, which also cuts a
  // memory request that was in flight.
  always_comb begin
    ir_load         = 1'b0;
    atualiza_pc     = 1'b0;
    pc_src          = 1'b0;
    WeR             = 1'b0;
    WeDM            = 1'b0;
    ReDM            = 1'b0;
    soma_ou_subtrai = 2'b00;
    ula_src_b       = 1'b0;
    wb_sel          = 2'b00;
    estado          = 3'd0;
    illegal         = 1'b0;
    if (!reset) begin
      estado  = state_r;
      illegal = illegal_r;
      if (state_r == EXEC || state_r == MEM || state_r == WB) begin
        soma_ou_subtrai = {1'b0, alu_sub};
        ula_src_b       = use_imm;
      end
      case (state_r)
        FETCH: ir_load = fetch_last;
        EXEC: begin
          if (op_r == OP_BRANCH) begin
            atualiza_pc = 1'b1;
            pc_src      = taken;
          end
        end
        MEM: begin
          if (op_r == OP_STORE) begin
            WeDM        = 1'b1;
            atualiza_pc = mem_ready;
          end else begin
            ReDM = 1'b1;
          end
        end
        WB: begin
          WeR         = 1'b1;
          atualiza_pc = 1'b1;
          pc_src      = (op_r == OP_JAL);
          if (op_r == OP_LOAD)     wb_sel = 2'b01;
          else if (op_r == OP_JAL) wb_sel = 2'b10;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uc_multiciclo.sv
// Directed testbench for uc_multiciclo: instance a uses IMEM_LAT=1, instance b
// uses IMEM_LAT=3. Inputs are shared; each instance has its own reset.
module tb_uc_multiciclo;

  logic       clk = 1'b0;
  logic       reset_a = 1'b0;
  logic       reset_b = 1'b0;
  logic [6:0] opcode = 7'b0110011;
  logic [2:0] funct3 = 3'b000;
  logic [6:0] funct7 = 7'b0100000;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;

  logic       ir_load_a, atualiza_pc_a, pc_src_a, WeR_a, WeDM_a, ReDM_a, ula_src_b_a, illegal_a;
  logic [1:0] soma_a, wb_sel_a;
  logic [2:0] estado_a;
  logic       ir_load_b, atualiza_pc_b, pc_src_b, WeR_b, WeDM_b, ReDM_b, ula_src_b_b, illegal_b;
  logic [1:0] soma_b, wb_sel_b;
  logic [2:0] estado_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uc_multiciclo #(.IMEM_LAT(1)) dut_a (
    .clk(clk), .reset(reset_a), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .zero(zero), .mem_ready(mem_ready), .ir_load(ir_load_a), .atualiza_pc(atualiza_pc_a),
    .pc_src(pc_src_a), .WeR(WeR_a), .WeDM(WeDM_a), .ReDM(ReDM_a),
    .soma_ou_subtrai(soma_a), .ula_src_b(ula_src_b_a), .wb_sel(wb_sel_a),
    .estado(estado_a), .illegal(illegal_a)
  );

  uc_multiciclo #(.IMEM_LAT(3)) dut_b (
    .clk(clk), .reset(reset_b), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .zero(zero), .mem_ready(mem_ready), .ir_load(ir_load_b), .atualiza_pc(atualiza_pc_b),
    .pc_src(pc_src_b), .WeR(WeR_b), .WeDM(WeDM_b), .ReDM(ReDM_b),
    .soma_ou_subtrai(soma_b), .ula_src_b(ula_src_b_b), .wb_sel(wb_sel_b),
    .estado(estado_b), .illegal(illegal_b)
  );

  // Packed view: {illegal, estado[2:0], ir_load, atualiza_pc, pc_src, WeR, WeDM, ReDM,
  //               soma[1:0], ula_src_b, wb_sel[1:0]}
  logic [14:0] obs_a, obs_b;
  assign obs_a = {illegal_a, estado_a, ir_load_a, atualiza_pc_a, pc_src_a, WeR_a, WeDM_a,
                  ReDM_a, soma_a, ula_src_b_a, wb_sel_a};
  assign obs_b = {illegal_b, estado_b, ir_load_b, atualiza_pc_b, pc_src_b, WeR_b, WeDM_b,
                  ReDM_b, soma_b, ula_src_b_b, wb_sel_b};

  function automatic logic [14:0] ex(input logic il, input logic [2:0] st,
                                     input logic ir, input logic apc, input logic psrc,
                                     input logic wer, input logic wedm, input logic redm,
                                     input logic [1:0] sos, input logic usb,
                                     input logic [1:0] wbs);
    ex = {il, st, ir, apc, psrc, wer, wedm, redm, sos, usb, wbs};
  endfunction

  task automatic chk(input string tag, input logic [14:0] obs, input logic [14:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %015b expected %015b", tag, obs, exp);
    end
  endtask

  task automatic nx();
    @(negedge clk);
  endtask

  initial begin
    #1 reset_a = 1'b1;
    reset_b = 1'b1;
    nx(); nx(); #1;
    chk("reset_a", obs_a, ex(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00));
    chk("reset_b", obs_b, ex(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00));

    // R sub, L=1: FETCH, DECODE, EXEC, WB
    nx(); reset_a = 1'b0; #1;
    chk("sub_fetch", obs_a, ex(0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00));
    nx(); #1; chk("sub_decode", obs_a, ex(0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00));
    nx(); #1; chk("sub_exec",   obs_a, ex(0, 2, 0, 0, 0, 0, 0, 0, 2'b01, 0, 2'b00));
    nx(); #1; chk("sub_wb",     obs_a, ex(0, 4, 0, 1, 0, 1, 0, 0, 2'b01, 0, 2'b00));

    // beq taken
    nx(); opcode = 7'b1100011; funct3 = 3'b000; funct7 = 7'b0000000; zero = 1'b1; #1;
    chk("beq_fetch",  obs_a, ex(0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00));
    nx(); #1; chk("beq_decode", obs_a, ex(0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00));
    nx(); #1; chk("beq_exec",   obs_a, ex(0, 2, 0, 1, 1, 0, 0, 0, 2'b01, 0, 2'b00));

    // bne with zero=1: not taken
    nx(); funct3 = 3'b001; #1;
    chk("bne_fetch", obs_a, ex(0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00));
    nx(); #1;
    nx(); #1; chk("bne_exec", obs_a, ex(0, 2, 0, 1, 0, 0, 0, 0, 2'b01, 0, 2'b00));

    // jal
    nx(); opcode = 7'b1101111; funct3 = 3'b000; zero = 1'b0; #1;
    nx(); #1;
    nx(); #1; chk("jal_exec", obs_a, ex(0, 2, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00));
    nx(); #1; chk("jal_wb",   obs_a, ex(0, 4, 0, 1, 1, 1, 0, 0, 2'b00, 0, 2'b10));

    // store, memory ready at once
    nx(); opcode = 7'b0100011; funct3 = 3'b011; mem_ready = 1'b1; #1;
    nx(); #1;
    nx(); #1; chk("st_exec", obs_a, ex(0, 2, 0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b00));
    nx(); #1; chk("st_mem",  obs_a, ex(0, 3, 0, 1, 0, 0, 1, 0, 2'b00, 1, 2'b00));
    nx(); #1; chk("st_done", obs_a, ex(0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00));

    // store stalled, then reset mid-MEM
    mem_ready = 1'b0;
    nx(); #1;
    nx(); #1;
    nx(); #1; chk("st2_mem1", obs_a, ex(0, 3, 0, 0, 0, 0, 1, 0, 2'b00, 1, 2'b00));
    nx(); #1; chk("st2_mem2", obs_a, ex(0, 3, 0, 0, 0, 0, 1, 0, 2'b00, 1, 2'b00));
    #1 reset_a = 1'b1; #1;
    chk("st2_cut", obs_a, ex(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00));
    nx(); reset_a = 1'b0; mem_ready = 1'b1; #1;
    chk("st2_release", obs_a, ex(0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00));

    // illegal opcode -> TRAP, sticky
    opcode = 7'b1110011; funct3 = 3'b000;
    nx(); #1; chk("ill_decode", obs_a, ex(0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00));
    for (int i = 0; i < 20; i++) begin
      nx(); #1; chk("ill_trap", obs_a, ex(1, 5, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00));
    end
    reset_a = 1'b1; #1;
    chk("ill_reset", obs_a, ex(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00));
    nx(); reset_a = 1'b0; opcode = 7'b0110011; #1;
    chk("ill_cleared", obs_a, ex(0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00));
    nx(); reset_a = 1'b1;

    // load, L=3, two stalled MEM cycles: 3 FETCH + DECODE + EXEC + 3 MEM + WB = 9
    opcode = 7'b0000011; funct3 = 3'b011; mem_ready = 1'b0;
    nx(); reset_b = 1'b0; #1;
    chk("ld_f1", obs_b, ex(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00));
    nx(); #1; chk("ld_f2",   obs_b, ex(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00));
    nx(); #1; chk("ld_f3",   obs_b, ex(0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00));
    nx(); #1; chk("ld_dec",  obs_b, ex(0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00));
    nx(); #1; chk("ld_exec", obs_b, ex(0, 2, 0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b00));
    nx(); #1; chk("ld_mem1", obs_b, ex(0, 3, 0, 0, 0, 0, 0, 1, 2'b00, 1, 2'b00));
    nx(); #1; chk("ld_mem2", obs_b, ex(0, 3, 0, 0, 0, 0, 0, 1, 2'b00, 1, 2'b00));
    nx(); mem_ready = 1'b1; #1;
    chk("ld_mem3", obs_b, ex(0, 3, 0, 0, 0, 0, 0, 1, 2'b00, 1, 2'b00));
    nx(); #1; chk("ld_wb",   obs_b, ex(0, 4, 0, 1, 0, 1, 0, 0, 2'b00, 1, 2'b01));
    nx(); #1; chk("ld_next", obs_b, ex(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
